// File: rtl/gshare_predictor.sv
`default_nettype none
// ============================================================================
// Module      : gshare_predictor
// Description : Gshare conditional-branch direction predictor for the IF stage.
//               A table of saturating counters is indexed by the fetch PC XOR
//               the speculative global history. Resolved branches train the
//               table and repair the history on a mispredict.
// Optional    : define BP_STATS_EN to add the resolved-branch and mispredict
//               statistics counters and their ports.
// Ports       : clk, rst                   - clock, synchronous active-high reset
//               lookup_valid/lookup_pc     - branch being fetched
//               stall                      - IF frozen, blocks history shift
//               p_out                      - predicted taken (combinational)
//               all_prediction             - speculative GHR snapshot
//               update_valid/pc/ghr/taken/mispredict - branch resolution
//               stat_branches/stat_mispredicts - statistics (BP_STATS_EN)
// Revision    : 1.0 - initial release
// ============================================================================
module gshare_predictor #(
  parameter int GHR_W     = 4,
  parameter int PHT_IDX_W = 6,
  parameter int CNT_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_valid,
  input  logic [31:0]       lookup_pc,
  input  logic              stall,
  output logic              p_out,
  output logic [GHR_W-1:0]  all_prediction,
  input  logic              update_valid,
  input  logic [31:0]       update_pc,
  input  logic [GHR_W-1:0]  update_ghr,
  input  logic              update_taken,
  input  logic              update_mispredict
`ifdef BP_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
`endif
);

  localparam int               c_PHT_ENTRIES = 1 << PHT_IDX_W;
  // Weakly not-taken: MSB clear, all lower bits set.
  localparam logic [CNT_W-1:0] c_CNT_WNT     = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] c_CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_MIN     = {CNT_W{1'b0}};

  logic [CNT_W-1:0]     pht_q [c_PHT_ENTRIES];
  logic [GHR_W-1:0]     ghr_q;
  logic [GHR_W-1:0]     ghr_d;

  logic [PHT_IDX_W-1:0] w_lkp_idx;
  logic [PHT_IDX_W-1:0] w_upd_idx;
  logic [CNT_W-1:0]     w_lkp_cnt;
  logic [CNT_W-1:0]     w_upd_cur;
  logic [CNT_W-1:0]     w_upd_nxt;

  // History is zero-extended so it folds into the low index bits only.
  assign w_lkp_idx = lookup_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_q);
  assign w_upd_idx = update_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(update_ghr);

  // Reads return the registered array, so a same-cycle write to the same
  // entry is only visible on the following cycle.
  assign w_lkp_cnt = pht_q[w_lkp_idx];
  assign w_upd_cur = pht_q[w_upd_idx];

  assign p_out          = lookup_valid & w_lkp_cnt[CNT_W-1];
  assign all_prediction = ghr_q;

  // Saturating counter step.
  always_comb begin
    w_upd_nxt = w_upd_cur;
    if (update_taken) begin
      if (w_upd_cur != c_CNT_MAX) begin
        w_upd_nxt = w_upd_cur + CNT_W'(1);
      end
    end else begin
      if (w_upd_cur != c_CNT_MIN) begin
        w_upd_nxt = w_upd_cur - CNT_W'(1);
      end
    end
  end

  // A mispredict repair takes priority over the speculative shift, since the
  // branch being fetched this cycle is on the wrong path.
  always_comb begin
    ghr_d = ghr_q;
    if (update_valid && update_mispredict) begin
      ghr_d = {update_ghr[GHR_W-2:0], update_taken};
    end else if (lookup_valid && !stall) begin
      ghr_d = {ghr_q[GHR_W-2:0], p_out};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q <= '0;
      for (int i = 0; i < c_PHT_ENTRIES; i++) begin
        pht_q[i] <= c_CNT_WNT;
      end
    end else begin
      ghr_q <= ghr_d;
      if (update_valid) begin
        pht_q[w_upd_idx] <= w_upd_nxt;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_mp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else if (update_valid) begin
      stat_br_q <= stat_br_q + 32'd1;
      if (update_mispredict) begin
        stat_mp_q <= stat_mp_q + 32'd1;
      end
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

  // PC bits outside the index window do not participate.
  logic w_unused_pc_bits;
  assign w_unused_pc_bits = ^{lookup_pc[31:PHT_IDX_W+2], lookup_pc[1:0],
                              update_pc[31:PHT_IDX_W+2], update_pc[1:0]};

endmodule
`default_nettype wire
